gpio_in_cond: RTL

- Input conditioning stage directly upstream of the GPIO AXI-Lite peripheral.
- Takes raw asynchronous pad inputs and passes them through a synchronizer and a per-bit debounce filter.
- Produces the clean `gpio_in` vector that the GPIO block reads at offset 0x08.
- Also detects rising/falling edges, latches per-pin pending bits and drives one level interrupt towards the CPU IRQ line.

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_bit_filter.sv | 78 +++++++
 rtl/gpio_in_cond.sv | 61 ++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: register map offsets, default geometry and the
// edge-event encoding used by the input conditioning path.
package gpio_pkg;

  // GPIO AXI-Lite register offsets
  localparam logic [7:0] GPIO_OFF_DIR = 8'h00;
  localparam logic [7:0] GPIO_OFF_OUT = 8'h04;
  localparam logic [7:0] GPIO_OFF_IN  = 8'h08;

  // Default geometry
  localparam int GPIO_WIDTH_DEF       = 16;
  localparam int GPIO_SYNC_STAGES_DEF = 2;

  // Edge-event type
  typedef enum logic [0:0] {
    EV_RISE = 1'b0,
    EV_FALL = 1'b1
  } gpio_ev_e;

endpackage

// File: rtl/gpio_bit_filter.sv
// One GPIO input bit: synchronizer chain, optional debounce filter, and
// flop-driven rising/falling edge pulses.
// GPIO_DEBOUNCE_EN defined   : a new level is accepted only after it has been
//                              seen at the synchronizer output for DB_CYCLES
//                              consecutive cycles.
// GPIO_DEBOUNCE_EN undefined : the synchronized level is taken every cycle.
module gpio_bit_filter
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES_DEF,
  parameter int DB_CNT_W    = 8,
  parameter int DB_CYCLES   = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic pad_in,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   stable;
  logic                   stable_d;

  // A debounce length the counter cannot reach would silently never accept.
  if ((SYNC_STAGES < 2) || (DB_CYCLES < 1) || (DB_CYCLES > (1 << DB_CNT_W) - 1)) begin : g_bad_cfg
    $error("gpio_bit_filter: illegal SYNC_STAGES/DB_CNT_W/DB_CYCLES combination");
  end

  // Plain shift chain: no logic between stages so every stage can resolve.
  always_ff @(posedge aclk) begin
    if (!aresetn) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic [DB_CNT_W-1:0] cnt;

  // Count consecutive mismatches; any agreement restarts the count.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_out == stable) begin
      cnt    <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_out;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end
`else
  // No filtering: follow the synchronized level one cycle later.
  always_ff @(posedge aclk) begin
    if (!aresetn) stable <= 1'b0;
    else          stable <= sync_out;
  end
`endif

  // Previous accepted level, the reference for edge detection.
  always_ff @(posedge aclk) begin
    if (!aresetn) stable_d <= 1'b0;
    else          stable_d <= stable;
  end

  // Both terms come straight from flops, so the pulses are one clean cycle.
  assign stable_o = stable;
  assign rise_o   = stable & ~stable_d;
  assign fall_o   = ~stable & stable_d;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-pin synchronize/debounce/edge detect, pending
// event latches and a single level interrupt towards the CPU.
// Optional debounce filtering is selected with the GPIO_DEBOUNCE_EN macro.
//
// pend_clr is a one-cycle pulse per pin (the W1C write strobe from the
// register block). There is no handshake: a set and a clear landing in the
// same cycle resolve to set, so no event can be lost by a racing clear.
module gpio_in_cond
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH_DEF,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES_DEF,
  parameter int DB_CNT_W    = 8,
  parameter int DB_CYCLES   = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] pend_clr,
  output logic [WIDTH-1:0] gpio_in_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] pend_o,
  output logic             irq
);

  logic [WIDTH-1:0] ev_set;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_bit_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CNT_W    (DB_CNT_W),
      .DB_CYCLES   (DB_CYCLES)
    ) u_bit_filter (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .pad_in   (pad_in[i]),
      .stable_o (gpio_in_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i])
    );
  end

  assign ev_set = (rise_o & rise_en) | (fall_o & fall_en);

  // Sticky pending bits; a new event outranks a same-cycle clear.
  always_ff @(posedge aclk) begin
    if (!aresetn) pend_o <= '0;
    else          pend_o <= ev_set | (pend_o & ~pend_clr);
  end

  // Registered interrupt so the CPU line never sees combinational glitches.
  always_ff @(posedge aclk) begin
    if (!aresetn) irq <= 1'b0;
    else          irq <= |(pend_o & irq_mask);
  end

endmodule
